// File: rtl/snappy_dec_pkg.sv
// Shared definitions for the snappy decompressor literal path.
// Default geometry of the literal scatter stage and the byte-order convention
// used on every multi-byte bus: byte 0 occupies the most significant lane.
package snappy_dec_pkg;

  localparam int BYTE_W        = 8;
  localparam int LS_IN_BYTES   = 16;
  localparam int LS_BANK_BYTES = 8;
  localparam int LS_NUM_BANKS  = 16;
  localparam int LS_ROW_W      = 9;

  // Bit offset of byte 'idx' inside an 'nbytes'-wide MSB-first bus.
  function automatic int byte_lsb(input int idx, input int nbytes);
    return (nbytes - 1 - idx) * BYTE_W;
  endfunction

endpackage

// File: rtl/lit_bank_slot.sv
// One bank's view of the shifted literal: picks its bank word, byte enables and row.
// Latency: combinational; the parent registers the result in its second stage.
// Backpressure: none here, the parent holds the inputs stable while stalled.
module lit_bank_slot
  import snappy_dec_pkg::*;
#(
  parameter  int BANK_IDX   = 0,
  parameter  int BANK_BYTES = LS_BANK_BYTES,
  parameter  int NUM_BANKS  = LS_NUM_BANKS,
  parameter  int ROW_W      = LS_ROW_W,
  parameter  int SPAN       = 3,
  localparam int BANK_W     = $clog2(NUM_BANKS),
  localparam int LANES      = SPAN * BANK_BYTES
) (
  input  logic [LANES*8-1:0]      lane_dat,
  input  logic [LANES-1:0]        lane_msk,
  input  logic [BANK_W-1:0]       base_bank,
  input  logic [ROW_W-1:0]        base_row,
  output logic [BANK_BYTES*8-1:0] slot_dat,
  output logic [BANK_BYTES-1:0]   slot_be,
  output logic [ROW_W-1:0]        slot_row
);

  // Distance of this bank from the first touched bank, modulo the bank count.
  logic [BANK_W-1:0] rel;
  assign rel = BANK_W'(BANK_IDX) - base_bank;

  // Select the relative bank word; banks below the base bank have wrapped and use the next row.
  always_comb begin
    slot_dat = '0;
    slot_be  = '0;
    slot_row = '0;
    for (int r = 0; r < SPAN; r++) begin
      if (rel == BANK_W'(r)) begin
        slot_dat = lane_dat[byte_lsb((r + 1) * BANK_BYTES - 1, LANES) +: BANK_BYTES*8];
        slot_be  = lane_msk[LANES - (r + 1) * BANK_BYTES +: BANK_BYTES];
      end
    end
    if (|slot_be) begin
      slot_row = base_row + ((BANK_W'(BANK_IDX) < base_bank) ? ROW_W'(1) : ROW_W'(0));
    end
  end

endmodule

// File: rtl/lit_scatter.sv
// Scatters one literal token over the history-buffer banks (row/byte-enable/data per bank).
// Latency: 2 cycles from accept to out_valid; full throughput of one token per cycle.
// Backpressure: valid/ready, all stages hold while out_ready is low; optional LIT_SCATTER_STATS_EN adds a byte counter.
module lit_scatter
  import snappy_dec_pkg::*;
#(
  parameter  int IN_BYTES   = LS_IN_BYTES,
  parameter  int BANK_BYTES = LS_BANK_BYTES,
  parameter  int NUM_BANKS  = LS_NUM_BANKS,
  parameter  int ROW_W      = LS_ROW_W,
  localparam int SH_W       = $clog2(BANK_BYTES),
  localparam int BANK_W     = $clog2(NUM_BANKS),
  localparam int LEN_W      = $clog2(IN_BYTES),
  localparam int ADDR_W     = ROW_W + BANK_W + SH_W
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [8*IN_BYTES-1:0]              in_data,
  input  logic [LEN_W-1:0]                   in_len_m1,
  input  logic [ADDR_W-1:0]                  in_addr,
  output logic                               out_valid,
  input  logic                               out_ready,
`ifdef LIT_SCATTER_STATS_EN
  input  logic                               stat_clr,
  output logic [31:0]                        stat_bytes,
`endif
  output logic [NUM_BANKS-1:0]               bank_we,
  output logic [NUM_BANKS*BANK_BYTES-1:0]    bank_be,
  output logic [NUM_BANKS*ROW_W-1:0]         bank_addr,
  output logic [NUM_BANKS*BANK_BYTES*8-1:0]  bank_data
);

  // A token shifted by up to BANK_BYTES-1 slots touches at most SPAN consecutive banks.
  localparam int SPAN  = IN_BYTES / BANK_BYTES + 1;
  localparam int LANES = SPAN * BANK_BYTES;

  logic v1_q, v1_d, v2_q, v2_d, adv2;
  logic [LANES*8-1:0]               s1_dat_q, s1_dat_d;
  logic [LANES-1:0]                 s1_msk_q, s1_msk_d;
  logic [BANK_W-1:0]                s1_bank_q, s1_bank_d;
  logic [ROW_W-1:0]                 s1_row_q, s1_row_d;
  logic [NUM_BANKS*BANK_BYTES*8-1:0] s2_dat_q, s2_dat_d, slot_dat_all;
  logic [NUM_BANKS*BANK_BYTES-1:0]   s2_be_q, s2_be_d, slot_be_all;
  logic [NUM_BANKS*ROW_W-1:0]        s2_row_q, s2_row_d, slot_row_all;

  logic [SH_W-1:0]         in_sh;
  logic [LEN_W:0]          len_p1;
  logic [IN_BYTES-1:0]     in_msk;
  logic [8*IN_BYTES-1:0]   in_dat_m;
  logic [LANES*8-1:0]      sh_dat;
  logic [LANES-1:0]        sh_msk;

  assign adv2     = ~v2_q | out_ready;
  assign in_ready = ~v1_q | adv2;
  assign in_sh    = in_addr[SH_W-1:0];
  assign len_p1   = {1'b0, in_len_m1} + (LEN_W+1)'(1);

  // Build the length mask, zero bytes past the token end, then shift right by the start slot.
  always_comb begin
    in_msk = ~({IN_BYTES{1'b1}} >> len_p1);
    for (int k = 0; k < IN_BYTES; k++) begin
      in_dat_m[k*8 +: 8] = in_data[k*8 +: 8] & {8{in_msk[k]}};
    end
    sh_dat = {in_dat_m, {(BANK_BYTES*8){1'b0}}} >> {in_sh, 3'b000};
    sh_msk = {in_msk, {BANK_BYTES{1'b0}}} >> in_sh;
  end

  // Stage 1 next state: load on accept, hold otherwise.
  always_comb begin
    v1_d      = v1_q;
    s1_dat_d  = s1_dat_q;
    s1_msk_d  = s1_msk_q;
    s1_bank_d = s1_bank_q;
    s1_row_d  = s1_row_q;
    if (in_ready) begin
      v1_d = in_valid;
      if (in_valid) begin
        s1_dat_d  = sh_dat;
        s1_msk_d  = sh_msk;
        s1_bank_d = in_addr[SH_W +: BANK_W];
        s1_row_d  = in_addr[ADDR_W-1 -: ROW_W];
      end
    end
  end

  // Stage 1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      s1_dat_q  <= '0;
      s1_msk_q  <= '0;
      s1_bank_q <= '0;
      s1_row_q  <= '0;
    end else begin
      v1_q      <= v1_d;
      s1_dat_q  <= s1_dat_d;
      s1_msk_q  <= s1_msk_d;
      s1_bank_q <= s1_bank_d;
      s1_row_q  <= s1_row_d;
    end
  end

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_slot
    lit_bank_slot #(
      .BANK_IDX   (gi),
      .BANK_BYTES (BANK_BYTES),
      .NUM_BANKS  (NUM_BANKS),
      .ROW_W      (ROW_W),
      .SPAN       (SPAN)
    ) u_slot (
      .lane_dat  (s1_dat_q),
      .lane_msk  (s1_msk_q),
      .base_bank (s1_bank_q),
      .base_row  (s1_row_q),
      .slot_dat  (slot_dat_all[gi*BANK_BYTES*8 +: BANK_BYTES*8]),
      .slot_be   (slot_be_all[gi*BANK_BYTES +: BANK_BYTES]),
      .slot_row  (slot_row_all[gi*ROW_W +: ROW_W])
    );
  end

  // Stage 2 next state: advance when the output is free or consumed; bubbles clear the bus.
  always_comb begin
    v2_d     = v2_q;
    s2_dat_d = s2_dat_q;
    s2_be_d  = s2_be_q;
    s2_row_d = s2_row_q;
    if (adv2) begin
      v2_d     = v1_q;
      s2_dat_d = v1_q ? slot_dat_all : '0;
      s2_be_d  = v1_q ? slot_be_all  : '0;
      s2_row_d = v1_q ? slot_row_all : '0;
    end
  end

  // Stage 2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q     <= 1'b0;
      s2_dat_q <= '0;
      s2_be_q  <= '0;
      s2_row_q <= '0;
    end else begin
      v2_q     <= v2_d;
      s2_dat_q <= s2_dat_d;
      s2_be_q  <= s2_be_d;
      s2_row_q <= s2_row_d;
    end
  end

  // A bank is written only when the set is valid and at least one of its bytes is enabled.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b] = v2_q & (|s2_be_q[b*BANK_BYTES +: BANK_BYTES]);
    end
  end

  assign out_valid = v2_q;
  assign bank_be   = s2_be_q;
  assign bank_addr = s2_row_q;
  assign bank_data = s2_dat_q;

`ifdef LIT_SCATTER_STATS_EN
  localparam int POP_W = $clog2(NUM_BANKS*BANK_BYTES + 1);

  logic [POP_W-1:0] emit_cnt;
  logic [32:0]      stat_sum;
  logic [31:0]      stat_q, stat_d;

  // Count bytes of each consumed write set; saturate, and let clear win over increment.
  always_comb begin
    emit_cnt = '0;
    for (int b = 0; b < NUM_BANKS*BANK_BYTES; b++) begin
      emit_cnt = emit_cnt + POP_W'(s2_be_q[b]);
    end
    stat_sum = {1'b0, stat_q} + 33'(emit_cnt);
    stat_d   = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else if (v2_q && out_ready) begin
      stat_d = stat_sum[32] ? 32'hFFFF_FFFF : stat_sum[31:0];
    end
  end

  // Statistics register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_bytes = stat_q;
`endif

endmodule
